// File: rtl/naneye_upstream_tx_if.sv
// Config-word handshake between register/control logic and the NanEye upstream transmitter.
interface naneye_upstream_tx_if #(
  parameter int WORD_W = 16
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/naneye_upstream_tx.sv
// NanEye upstream config transmitter: sends one held word as BMC symbols inside the sensor window.
// Optional even-parity bit after the data is enabled by defining UPSTREAM_PARITY_EN.
module naneye_upstream_tx #(
  parameter int WORD_W       = 16,
  parameter int HALF_BIT_CYC = 4,
  parameter int GUARD_CYC    = 8
) (
  input  logic                  SCLOCK,
  input  logic                  RESET,
  input  logic                  upstream_win,
  naneye_upstream_tx_if.slave   cfg,
  output logic                  SENSOR_TX,
  output logic                  SENSOR_OE,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  tx_abort
);

  localparam int HC_W = $clog2(HALF_BIT_CYC);
  localparam int BI_W = $clog2(WORD_W + 2);
  localparam int GC_W = $clog2(GUARD_CYC + 1);

  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_BIT_CYC - 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(WORD_W - 1);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(GUARD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_WIN, S_GUARD, S_START, S_DATA, S_PARITY, S_TRAIL
  } state_t;

  state_t            state_q, state_n;
  logic [HC_W-1:0]   hcnt_q, hcnt_n;
  logic              half_q, half_n;
  logic [BI_W-1:0]   bidx_q, bidx_n;
  logic [GC_W-1:0]   gcnt_q, gcnt_n;
  logic [WORD_W-1:0] sreg_q, sreg_n;
  logic              tx_q, tx_n;
  logic              oe_q, oe_n;
  logic              done_q, done_n;
  logic              abort_q, abort_n;
  logic              win_q;
`ifdef UPSTREAM_PARITY_EN
  logic              par_q, par_n;
`endif

  logic win_rise, active, bit_end, cur_bit;

  assign win_rise = upstream_win & ~win_q;
  assign active   = (state_q == S_GUARD) || (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_TRAIL);
  assign bit_end  = half_q && (hcnt_q == HC_LAST);

  // Value of the symbol currently on the line; decides the mid-bit toggle.
  always_comb begin
    cur_bit = 1'b0;
    case (state_q)
      S_START:  cur_bit = 1'b1;
      S_DATA:   cur_bit = sreg_q[WORD_W-1];
`ifdef UPSTREAM_PARITY_EN
      S_PARITY: cur_bit = par_q;
`endif
      default:  cur_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state_q;
    hcnt_n  = hcnt_q;
    half_n  = half_q;
    bidx_n  = bidx_q;
    gcnt_n  = gcnt_q;
    sreg_n  = sreg_q;
    tx_n    = tx_q;
    oe_n    = oe_q;
    done_n  = 1'b0;
    abort_n = 1'b0;
`ifdef UPSTREAM_PARITY_EN
    par_n   = par_q;
`endif

    // A window fall on the very last TRAIL cycle still completes the word.
    if (active && !upstream_win && !((state_q == S_TRAIL) && bit_end)) begin
      state_n = S_IDLE;
      oe_n    = 1'b0;
      tx_n    = 1'b0;
      abort_n = 1'b1;
    end else begin
      if (active && (state_q != S_GUARD)) begin
        if (hcnt_q == HC_LAST) begin
          hcnt_n = '0;
          half_n = ~half_q;
          if (!half_q && cur_bit) tx_n = ~tx_q;
        end else begin
          hcnt_n = hcnt_q + 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          tx_n = 1'b0;
          oe_n = 1'b0;
          if (cfg.cfg_valid) begin
            state_n = S_WAIT_WIN;
            sreg_n  = cfg.cfg_data;
`ifdef UPSTREAM_PARITY_EN
            par_n   = ^cfg.cfg_data;
`endif
          end
        end
        S_WAIT_WIN: begin
          if (win_rise) begin
            state_n = S_GUARD;
            oe_n    = 1'b1;
            tx_n    = 1'b0;
            gcnt_n  = '0;
          end
        end
        S_GUARD: begin
          if (gcnt_q == GC_LAST) begin
            state_n = S_START;
            tx_n    = 1'b1;
            hcnt_n  = '0;
            half_n  = 1'b0;
          end else begin
            gcnt_n = gcnt_q + 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_n = S_DATA;
            bidx_n  = '0;
            tx_n    = ~tx_q;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            sreg_n = {sreg_q[WORD_W-2:0], 1'b0};
            if (bidx_q == BI_LAST) begin
`ifdef UPSTREAM_PARITY_EN
              state_n = S_PARITY;
              tx_n    = ~tx_q;
`else
              state_n = S_TRAIL;
              tx_n    = 1'b0;
`endif
            end else begin
              bidx_n = bidx_q + 1'b1;
              tx_n   = ~tx_q;
            end
          end
        end
`ifdef UPSTREAM_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_n = S_TRAIL;
            tx_n    = 1'b0;
          end
        end
`endif
        S_TRAIL: begin
          tx_n = 1'b0;
          if (bit_end) begin
            state_n = S_IDLE;
            oe_n    = 1'b0;
            done_n  = 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          oe_n    = 1'b0;
          tx_n    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      half_q  <= 1'b0;
      bidx_q  <= '0;
      gcnt_q  <= '0;
      sreg_q  <= '0;
      tx_q    <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      win_q   <= 1'b0;
`ifdef UPSTREAM_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      hcnt_q  <= hcnt_n;
      half_q  <= half_n;
      bidx_q  <= bidx_n;
      gcnt_q  <= gcnt_n;
      sreg_q  <= sreg_n;
      tx_q    <= tx_n;
      oe_q    <= oe_n;
      done_q  <= done_n;
      abort_q <= abort_n;
      win_q   <= upstream_win;
`ifdef UPSTREAM_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  assign cfg.cfg_ready = (state_q == S_IDLE);
  assign tx_busy       = (state_q != S_IDLE);
  assign SENSOR_TX     = tx_q;
  assign SENSOR_OE     = oe_q;
  assign tx_done       = done_q;
  assign tx_abort      = abort_q;

endmodule

// File: tb/tb_naneye_upstream_tx.sv
// Scoreboard bench for naneye_upstream_tx: words queued at accept, decoded BMC frames compared on tx_done.
module tb_naneye_upstream_tx;
  localparam int W = 16;
  localparam int H = 4;
  localparam int G = 8;
`ifdef UPSTREAM_PARITY_EN
  localparam int FRAME = W + 3;
`else
  localparam int FRAME = W + 2;
`endif
  localparam int OE_LEN = G + FRAME * 2 * H;

  logic SCLOCK = 1'b0;
  logic RESET = 1'b0;
  logic upstream_win = 1'b0;
  logic SENSOR_TX, SENSOR_OE, tx_busy, tx_done, tx_abort;

  naneye_upstream_tx_if #(.WORD_W(W)) cfg_if ();

  naneye_upstream_tx #(.WORD_W(W), .HALF_BIT_CYC(H), .GUARD_CYC(G)) dut (
    .SCLOCK(SCLOCK), .RESET(RESET), .upstream_win(upstream_win), .cfg(cfg_if),
    .SENSOR_TX(SENSOR_TX), .SENSOR_OE(SENSOR_OE), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_abort(tx_abort)
  );

  always #5 SCLOCK = ~SCLOCK;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic smp[$];
  int n_done = 0;
  int n_abort = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check_frame();
    logic [W-1:0] word, got;
    logic [31:0] bits;
    int gerr, berr, base;
    logic prev;
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    word = exp_q.pop_front();
    chk("oe_len", smp.size(), OE_LEN);
    if (smp.size() != OE_LEN) return;
    gerr = 0;
    for (int i = 0; i < G; i++) if (smp[i] !== 1'b0) gerr++;
    chk("guard_low", gerr, 0);
    berr = 0;
    bits = '0;
    for (int b = 0; b < FRAME; b++) begin
      base = G + b * 2 * H;
      bits[b] = smp[base + H/2] ^ smp[base + H + H/2];
      prev = (b == 0) ? 1'b0 : smp[base - 1];
      if (b < FRAME - 1 && smp[base] === prev) berr++;
    end
    chk("bmc_edges", berr, 0);
    chk("start_bit", bits[0], 1);
    for (int i = 0; i < W; i++) got[W-1-i] = bits[1+i];
    chk("data", got, word);
`ifdef UPSTREAM_PARITY_EN
    chk("parity", bits[W+1], ^word);
`endif
    base = G + (FRAME - 1) * 2 * H;
    chk("trail_low", smp[base + H/2] | smp[base + H + H/2], 0);
  endtask

  always @(negedge SCLOCK) begin
    if (!RESET) begin
      smp.delete();
      exp_q.delete();
    end else begin
      if (SENSOR_OE) smp.push_back(SENSOR_TX);
      if (tx_done || tx_abort) chk("done_abort_excl", tx_done & tx_abort, 0);
      if (tx_done) begin
        n_done++;
        check_frame();
        smp.delete();
      end
      if (tx_abort) begin
        n_abort++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        smp.delete();
      end
    end
  end

  task automatic tick();
    @(negedge SCLOCK);
    #1;
  endtask

  task automatic send(input logic [W-1:0] word);
    int t = 0;
    while (cfg_if.cfg_ready !== 1'b1 && t < 50) begin tick(); t++; end
    chk("ready_wait", cfg_if.cfg_ready, 1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = word;
    tick();
    cfg_if.cfg_valid = 1'b0;
    exp_q.push_back(word);
    chk("ready_drop", cfg_if.cfg_ready, 0);
    chk("busy_held", tx_busy, 1);
  endtask

  task automatic go_and_wait();
    int d0, t;
    repeat (10) tick();
    chk("no_oe_before_win", SENSOR_OE, 0);
    upstream_win = 1'b1;
    d0 = n_done;
    t = 0;
    while (n_done == d0 && t < 400) begin tick(); t++; end
    chk("done_seen", n_done - d0, 1);
    chk("ready_at_done", cfg_if.cfg_ready, 1);
    upstream_win = 1'b0;
    repeat (3) tick();
    chk("done_pulse", n_done - d0, 1);
    chk("busy_clear", tx_busy, 0);
  endtask

  task automatic wait_oe();
    int t = 0;
    while (SENSOR_OE !== 1'b1 && t < 40) begin tick(); t++; end
    chk("oe_rise", SENSOR_OE, 1);
  endtask

  initial begin
    int bad, a0, d0;
    logic [W-1:0] words[6];
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    words[0] = 16'hA5C3; words[1] = 16'h0000; words[2] = 16'hFFFF;
    words[3] = 16'h8001; words[4] = W'($urandom); words[5] = W'($urandom);

    repeat (2) tick();
    chk("rst_ready", cfg_if.cfg_ready, 1);
    chk("rst_oe", SENSOR_OE, 0);
    chk("rst_busy", tx_busy, 0);
    RESET = 1'b1;

    bad = 0;
    repeat (100) begin
      tick();
      if (cfg_if.cfg_ready !== 1'b1 || SENSOR_OE !== 1'b0 || SENSOR_TX !== 1'b0 ||
          tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_abort !== 1'b0) bad++;
    end
    chk("idle_100", bad, 0);

    foreach (words[i]) begin
      send(words[i]);
      go_and_wait();
    end

    // abort mid-data: sample 59 after OE rise sits inside data bit 5
    send(16'h3C5A);
    repeat (10) tick();
    upstream_win = 1'b1;
    wait_oe();
    a0 = n_abort; d0 = n_done;
    repeat (G + 6 * 2 * H + 3) tick();
    chk("oe_before_drop", SENSOR_OE, 1);
    upstream_win = 1'b0;
    tick();
    chk("abort_oe", SENSOR_OE, 0);
    chk("abort_tx", SENSOR_TX, 0);
    chk("abort_pulse", tx_abort, 1);
    chk("abort_no_done", tx_done, 0);
    chk("abort_ready", cfg_if.cfg_ready, 1);
    tick();
    chk("abort_one_cycle", tx_abort, 0);
    repeat (20) tick();
    chk("abort_count", n_abort - a0, 1);
    chk("abort_done_count", n_done - d0, 0);
    chk("abort_sb_drop", exp_q.size(), 0);

    // window already high at accept must not launch
    upstream_win = 1'b1;
    repeat (3) tick();
    send(16'h1234);
    bad = 0;
    repeat (50) begin tick(); if (SENSOR_OE !== 1'b0) bad++; end
    chk("win_high_no_tx", bad, 0);
    upstream_win = 1'b0;
    repeat (5) tick();
    chk("wait_fall_busy", tx_busy, 1);
    chk("wait_fall_oe", SENSOR_OE, 0);
    go_and_wait();

    // asynchronous reset in the middle of DATA with the line high
    send(16'hF0F0);
    repeat (10) tick();
    upstream_win = 1'b1;
    wait_oe();
    bad = 0;
    repeat (G + 3 * 2 * H) tick();
    while (SENSOR_TX !== 1'b1 && bad < 20) begin tick(); bad++; end
    chk("pre_rst_tx_high", SENSOR_TX, 1);
    RESET = 1'b0;
    #1;
    chk("async_rst_oe", SENSOR_OE, 0);
    chk("async_rst_tx", SENSOR_TX, 0);
    chk("async_rst_ready", cfg_if.cfg_ready, 1);
    upstream_win = 1'b0;
    repeat (2) tick();
    RESET = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", tx_busy, 0);

    send(16'h5A5A);
    go_and_wait();

    repeat (5) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
